// File: rtl/uart_tx.sv
// 8N1 serial transmitter: a one-cycle flag plus a byte produces one LSB-first frame on tx.
// Each bit lasts MAX_CNT clocks. tx is registered, so it lags the bit counters by one clock.
module uart_tx #(
    parameter int MAX_CNT = 5208
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] data,
    input  logic       flag,
    output logic       tx
);

    localparam int              CNT_W    = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CNT - 1);
    localparam logic [3:0]      BIT_LAST = 4'd9;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state;
    logic [7:0]       shreg;
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_cnt;

    logic             baud_wrap;
    logic [2:0]       data_idx;
    logic             tx_bit;

    assign baud_wrap = (baud_cnt == CNT_LAST);
    assign data_idx  = bit_cnt[2:0] - 3'd1;

    // Index 0 is the start bit, 1..8 carry shreg LSB first, 9 is the stop bit.
    always_comb begin
        tx_bit = 1'b1;
        if (bit_cnt == 4'd0) begin
            tx_bit = 1'b0;
        end else if (bit_cnt <= 4'd8) begin
            tx_bit = shreg[data_idx];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shreg    <= 8'h00;
            baud_cnt <= '0;
            bit_cnt  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (flag) begin
                        state    <= SEND;
                        shreg    <= data;
                        baud_cnt <= '0;
                        bit_cnt  <= 4'd0;
                    end
                end
                SEND: begin
                    // Requests arriving here are dropped, not queued.
                    tx <= tx_bit;
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state   <= IDLE;
                            bit_cnt <= 4'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at MAX_CNT=4: idle, single frames, back-to-back frames,
// ignored mid-frame requests, asynchronous abort and a held-high flag.
module tb_uart_tx;

    localparam int M     = 4;
    localparam int FRAME = 10 * M;

    logic       clk = 1'b0;
    logic       rstn;
    logic       flag;
    logic [7:0] data;
    logic       tx;

    int checks = 0;
    int errors = 0;

    // Hand-computed frames for bytes 1..7; bit k of each vector is frame bit k.
    logic [9:0] small_pat [1:7] = '{
        10'b1000000010, 10'b1000000100, 10'b1000000110, 10'b1000001000,
        10'b1000001010, 10'b1000001100, 10'b1000001110
    };

    uart_tx #(.MAX_CNT(M)) dut (
        .clk  (clk),
        .rstn (rstn),
        .data (data),
        .flag (flag),
        .tx   (tx)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: tx=%b expected %b at t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic idleCheck(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput(tag, tx, 1'b1);
        end
    endtask

    // Called at a negedge; the following posedge is the accepting edge N.
    // After edge N+j the line must carry frame bit (j-1)/M for j=1..10*M.
    task automatic applyStimulus(input logic [7:0] byte_val, input logic [9:0] pattern,
                                 input string tag, input int hold, input int inject_at,
                                 input logic [7:0] inject_data, input int abort_at);
        data = byte_val;
        flag = 1'b1;
        for (int j = 0; j <= FRAME; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j == hold - 1) flag = 1'b0;
            if (j == inject_at) begin
                flag = 1'b1;
                data = inject_data;
            end else if (j == inject_at + 1) begin
                flag = 1'b0;
            end
            if (j == 0) checkOutput({tag, "_accept"}, tx, 1'b1);
            else        checkOutput(tag, tx, pattern[(j - 1) / M]);
            if (j == abort_at) begin
                #1 rstn = 1'b0;
                #1 checkOutput({tag, "_async_rst"}, tx, 1'b1);
                return;
            end
        end
    endtask

    initial begin
        rstn = 1'b1;
        flag = 1'b0;
        data = 8'h00;
        #3 rstn = 1'b0;

        $display("[TB] reset and idle");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset_hold", tx, 1'b1);
        end
        rstn = 1'b1;
        idleCheck("idle_after_reset", 5);

        $display("[TB] all-zero byte");
        applyStimulus(8'h00, 10'b1000000000, "zero_frame", 1, -10, 8'h00, -10);
        idleCheck("zero_idle", 6);

        $display("[TB] back-to-back bytes 1..7");
        for (int b = 1; b <= 7; b++) begin
            applyStimulus(8'(b), small_pat[b], $sformatf("byte_%0d", b), 1, -10, 8'h00, -10);
        end
        idleCheck("b2b_idle", 3);

        $display("[TB] request during frame is ignored");
        applyStimulus(8'h3C, 10'b1001111000, "busy_ignore", 1, 10, 8'hFF, -10);
        idleCheck("no_queued_frame", 3 * M);

        $display("[TB] reset during data bit 4");
        applyStimulus(8'hEF, 10'b1111011110, "abort", 1, -10, 8'h00, 22);
        flag = 1'b0;
        @(negedge clk);
        checkOutput("abort_in_reset", tx, 1'b1);
        @(negedge clk);
        checkOutput("abort_in_reset", tx, 1'b1);
        rstn = 1'b1;
        idleCheck("abort_idle", 3);
        applyStimulus(8'h96, 10'b1100101100, "after_abort", 1, -10, 8'h00, -10);
        idleCheck("after_abort_idle", 3);

        $display("[TB] flag held high for 50 cycles");
        applyStimulus(8'hA5, 10'b1101001010, "held_first", 50, -10, 8'h00, -10);
        applyStimulus(8'hA5, 10'b1101001010, "held_second", 9, -10, 8'h00, -10);
        idleCheck("held_idle", 2 * M);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Fixed-format asynchronous serial transmitter: 8 data bits, no parity, one stop bit (8N1), LSB first. It turns a one-cycle `flag` strobe plus an 8-bit `data` byte into one serial frame on `tx`. Bit period is `MAX_CNT` system clocks; the default of 5208 gives 9600 baud from a 50 MHz clock. It sits at the system-side edge of the RS232 path and drives the line directly.

## Interface
- `MAX_CNT`, default 5208: clocks per bit. Legal range is ≥ 2.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rstn`  input  1  reset; one clock; reset is asynchronous and active-low.
- `data`  input  8  byte to send; sampled only on the accepting edge.
- `flag`  input  1  send request, active high, nominally one cycle wide.
- `tx`  output  1  serial line; idles high; registered output.

## Operation
- Internal state:
  - `busy` flag.
  - Latched byte `shreg[7:0]`.
  - Baud counter `baud_cnt`, range 0..MAX_CNT-1, width ceil(log2(MAX_CNT)).
  - Bit index `bit_cnt`, range 0..9, 4 bits.
- Reset (asynchronous, `rstn`=0):
  - `tx`=1, `busy`=0.
  - `baud_cnt`=0, `bit_cnt`=0, `shreg`=0.
  - Reset mid-frame aborts the frame; `tx` returns high immediately, without waiting for a clock edge.
- IDLE (`busy`=0):
  - `tx` is held at 1.
  - `flag`=1 sampled at an edge → accept: `shreg`←`data`, `busy`←1, `baud_cnt`←0, `bit_cnt`←0.
- SEND (`busy`=1):
  - `baud_cnt` increments each clock and wraps from MAX_CNT-1 to 0.
  - On wrap, `bit_cnt` increments.
  - When `bit_cnt`=9 and `baud_cnt`=MAX_CNT-1, `busy`←0, `bit_cnt`←0, `baud_cnt`←0.
- `tx` value per bit index:
  - Index 0: start bit, 0.
  - Index 1..8: `shreg[bit_cnt-1]`, LSB first.
  - Index 9: stop bit, 1.
  - `tx` is registered from this decode, so it lags the counters by one clock.
- `flag` while `busy`=1 is ignored. The in-flight frame and `shreg` are unaffected, and the request is not queued.
- `data` changes while `busy`=1 have no effect.
- A `flag` held high for several cycles starts exactly one frame.
  - If it is still high after `busy` clears, a new frame starts on the next edge that samples it with `busy`=0.

## Timing
- Reference edge N: the edge where `flag`=1 is sampled with `busy`=0.
- Bit k (k=0..9) is on `tx` from edge N+1+k·MAX_CNT through edge N+(k+1)·MAX_CNT. Each bit lasts exactly MAX_CNT clocks.
- Accept-to-start-bit latency is 1 clock: `tx` falls at edge N+1.
- The frame lasts 10·MAX_CNT clocks. The stop bit ends at edge N+1+10·MAX_CNT, after which `tx` stays 1.
- `busy` is 1 from edge N until it clears at edge N+10·MAX_CNT.
  - A `flag` sampled at that same edge is ignored.
  - The earliest accepted follow-on request is at edge N+10·MAX_CNT+1.
  - Its start bit begins at edge N+10·MAX_CNT+2, so the stop bit is never shortened.
- Back-to-back frames spaced ≥10·MAX_CNT+1 clocks apart are all transmitted without loss.

## Test plan
1. Reset held low, then released → `tx`=1 throughout and stays 1 with `flag`=0.
2. MAX_CNT=5208, `data`=8'h00, one-cycle `flag` → `tx` is:
   - 0 for 9·5208 clocks starting one clock after the accepting edge;
   - then 1 for 5208 clocks;
   - then idle 1.
3. `data`=1..7, each pulsed with `flag` 52081 clocks apart → for each byte:
   - correct LSB-first waveform; e.g. 8'h05 gives bit pattern 0,1,0,1,0,0,0,0,0,1;
   - no frame dropped.
4. Extra `flag` pulse mid-frame with a different `data` → the current frame completes unchanged and no second frame is sent.
5. `rstn` asserted during data bit 4 → `tx` goes 1 asynchronously. After release, a new `flag` sends a clean full frame.
6. MAX_CNT=4, `data`=8'hA5, `flag` held high for 50 cycles →
   - the first frame is 40 clocks, bits 0,1,0,1,0,0,1,0,1,1;
   - a second 8'hA5 frame starts right after `busy` clears, since `flag` is still high.
